led_blink_notifier: RTL and testbench

- Output-side counterpart to the switch debouncer. It turns a single-cycle internal event pulse into a human-visible LED pattern: num blinks, each with a fixed on-time and off-time.
- It sits between control logic (for example a training-done or error-code event) and a board LED.
- It uses the same free-running-prescaler style as the input debouncer: phase timing advances only on slow ticks.

---
 rtl/led_blink_notifier.sv | 114 +++++++++++
 tb/tb_led_blink_notifier.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_notifier.sv
// Event-to-LED notifier: a trig pulse starts num blinks of ON_TICKS on / OFF_TICKS off,
// with phase timing advancing on prescaler ticks of 2^PRESC_W clock cycles.
module led_blink_notifier #(
  parameter int unsigned PRESC_W   = 20,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       trig,
  input  logic [3:0] num,
  input  logic       clr_ovr,
  output logic       led,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned MaxTicks = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned PhaseW   = $clog2(MaxTicks) + 1;
  localparam logic [PhaseW-1:0] OnLast  = PhaseW'(ON_TICKS - 1);
  localparam logic [PhaseW-1:0] OffLast = PhaseW'(OFF_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PhaseW-1:0]  phase_q, phase_d;
  logic [3:0]         remain_q, remain_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               tick;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    phase_d   = phase_q;
    remain_d  = remain_q;
    tick      = busy_q && (presc_q == '1);

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        phase_d = '0;
        if (trig && (num != 4'd0)) begin
          remain_d = num;
          state_d  = StOn;
        end
      end
      StOn: begin
        presc_d = presc_q + PRESC_W'(1);
        if (tick) begin
          if (phase_q == OnLast) begin
            phase_d = '0;
            state_d = StOff;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
      end
      StOff: begin
        presc_d = presc_q + PRESC_W'(1);
        if (tick) begin
          if (phase_q == OffLast) begin
            phase_d  = '0;
            remain_d = remain_q - 4'd1;
            // Exit on the last count so remain never wraps below zero.
            state_d  = (remain_q == 4'd1) ? StIdle : StOn;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Set beats clear when both happen in the same cycle.
    if (trig && busy_q) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      phase_q   <= '0;
      remain_q  <= 4'd0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_led_blink_notifier.sv
// Directed bench for led_blink_notifier with PRESC_W=2, ON_TICKS=2, OFF_TICKS=1:
// one blink is 8 cycles on plus 4 cycles off.
module tb_led_blink_notifier;

  logic       clk = 1'b0;
  logic       res;
  logic       trig;
  logic [3:0] num;
  logic       clr_ovr;
  logic       led;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int passes = 0;

  led_blink_notifier #(
    .PRESC_W  (2),
    .ON_TICKS (2),
    .OFF_TICKS(1)
  ) dut (
    .clk    (clk),
    .res    (res),
    .trig   (trig),
    .num    (num),
    .clr_ovr(clr_ovr),
    .led    (led),
    .busy   (busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Advance through one rising edge; inputs set afterwards land on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1; trig = 1'b0; num = 4'd0; clr_ovr = 1'b0;
    step(); step();
    res = 1'b0;
    step();
    checks++;
    if ({led, busy, overrun} !== 3'b000) $display("FAIL reset_state got %b exp 000", {led, busy, overrun});
    else passes++;
    // Start a pattern and provoke overrun so every output is 1 before the reset pulse.
    trig = 1'b1; num = 4'($urandom_range(1, 15));
    step();
    step();
    trig = 1'b0;
    step();
    checks++;
    if ({led, busy, overrun} !== 3'b111) $display("FAIL pre_reset got %b exp 111", {led, busy, overrun});
    else passes++;
    #2;
    trig = 1'($urandom); num = 4'($urandom); clr_ovr = 1'($urandom);
    res = 1'b1;
    #1;
    checks++;
    if ({led, busy, overrun} !== 3'b000) $display("FAIL async_reset got %b exp 000", {led, busy, overrun});
    else passes++;
    for (int i = 0; i < 3; i++) begin
      trig = 1'($urandom); num = 4'($urandom); clr_ovr = 1'($urandom);
      step();
    end
    res = 1'b0; trig = 1'b0; clr_ovr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({led, busy, overrun} !== 3'b000)
        $display("FAIL after_reset k=%0d got %b exp 000", k, {led, busy, overrun});
      else passes++;
    end
  endtask

  task automatic test_single_blink();
    logic exp_led, exp_busy;
    trig = 1'b1; num = 4'd1;
    step();
    trig = 1'b0; num = 4'd9;
    for (int k = 1; k <= 16; k++) begin
      exp_busy = (k <= 12);
      exp_led  = (k <= 8);
      checks++;
      if ({led, busy} !== {exp_led, exp_busy})
        $display("FAIL single k=%0d got led/busy %b exp %b", k, {led, busy}, {exp_led, exp_busy});
      else passes++;
      step();
    end
  endtask

  task automatic test_multi_blink();
    logic exp_led, exp_busy, prev;
    int rises = 0;
    prev = 1'b0;
    trig = 1'b1; num = 4'd3;
    step();
    trig = 1'b0; num = 4'd0;
    for (int k = 1; k <= 40; k++) begin
      exp_busy = (k <= 36);
      exp_led  = exp_busy && (((k - 1) % 12) < 8);
      checks++;
      if ({led, busy} !== {exp_led, exp_busy})
        $display("FAIL multi k=%0d got led/busy %b exp %b", k, {led, busy}, {exp_led, exp_busy});
      else passes++;
      if (led && !prev) rises++;
      prev = led;
      step();
    end
    checks++;
    if (rises !== 3) $display("FAIL multi_rises got %0d exp 3", rises);
    else passes++;
  endtask

  task automatic test_num_zero();
    trig = 1'b1; num = 4'd0;
    step();
    trig = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      checks++;
      if ({led, busy, overrun} !== 3'b000)
        $display("FAIL num_zero k=%0d got %b exp 000", k, {led, busy, overrun});
      else passes++;
      step();
    end
  endtask

  task automatic test_overrun();
    logic exp_led, exp_busy, exp_ovr, prev;
    int rises = 0;
    prev = 1'b0;
    trig = 1'b1; num = 4'd2;
    step();
    trig = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      exp_busy = (k <= 24);
      exp_led  = exp_busy && (((k - 1) % 12) < 8);
      exp_ovr  = (k >= 6);
      checks++;
      if ({led, busy, overrun} !== {exp_led, exp_busy, exp_ovr})
        $display("FAIL overrun_pat k=%0d got led/busy/ovr %b exp %b", k,
                 {led, busy, overrun}, {exp_led, exp_busy, exp_ovr});
      else passes++;
      if (led && !prev) rises++;
      prev = led;
      // Extra triggers mid-pattern and on the final busy cycle must be dropped.
      trig = (k == 5) || (k == 24);
      num  = 4'd7;
      step();
    end
    trig = 1'b0;
    checks++;
    if (rises !== 2) $display("FAIL overrun_rises got %0d exp 2", rises);
    else passes++;

    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) $display("FAIL clr_ovr got %b exp 0", overrun);
    else passes++;

    trig = 1'b1; num = 4'd1;
    step();
    clr_ovr = 1'b1;
    step();
    trig = 1'b0; clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b1) $display("FAIL set_wins got %b exp 1", overrun);
    else passes++;
    for (int k = 3; k <= 13; k++) step();
    checks++;
    if (busy !== 1'b0) $display("FAIL overrun_end busy got %b exp 0", busy);
    else passes++;
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_led, exp_busy;
    int j;
    trig = 1'b1; num = 4'd1;
    step();
    trig = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      j = (k <= 13) ? k : k - 13;
      exp_busy = (j >= 1) && (j <= 12);
      exp_led  = (j >= 1) && (j <= 8);
      checks++;
      if ({led, busy} !== {exp_led, exp_busy})
        $display("FAIL b2b k=%0d got led/busy %b exp %b", k, {led, busy}, {exp_led, exp_busy});
      else passes++;
      if (k == 14) begin
        checks++;
        if (overrun !== 1'b0) $display("FAIL b2b_no_ovr got %b exp 0", overrun);
        else passes++;
      end
      trig = (k == 13);
      num  = 4'd1;
      step();
    end
    trig = 1'b0;
  endtask

  task automatic test_abort();
    trig = 1'b1; num = 4'd3;
    step();
    trig = 1'b0;
    step(); step();
    checks++;
    if ({led, busy} !== 2'b11) $display("FAIL abort_pre got %b exp 11", {led, busy});
    else passes++;
    #2;
    res = 1'b1;
    #1;
    checks++;
    if ({led, busy} !== 2'b00) $display("FAIL abort_now got %b exp 00", {led, busy});
    else passes++;
    step();
    res = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({led, busy} !== 2'b00) $display("FAIL abort_after k=%0d got %b exp 00", k, {led, busy});
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_blink();
    test_multi_blink();
    test_num_zero();
    test_overrun();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
